// File: rtl/button_conditioner_pkg.sv
// Shared constants for the pushbutton/switch front end: channel indices,
// default timing in clk cycles and the per-button FSM state encoding.
package button_conditioner_pkg;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_MID   = 4;

    localparam int unsigned DEF_N_BTN    = 5;
    localparam int unsigned DEF_DEB_CYC  = 2_000_000;
    localparam int unsigned DEF_HOLD_CYC = 60_000_000;
    localparam int unsigned DEF_REP_CYC  = 15_000_000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESS  = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

endpackage

// File: rtl/button_conditioner_channel.sv
// One input: 2-flop synchroniser, debounce counter, registered level and
// (when HAS_FSM) the press/long/repeat event FSM; all outputs registered.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
    parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
    parameter int unsigned REP_CYC  = DEF_REP_CYC,
    parameter bit          HAS_FSM  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rpt_o,
    output logic long_o
);

    localparam int unsigned DW = $clog2(DEB_CYC);
    localparam logic [DW-1:0] DEB_T = DW'(DEB_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          level_q;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // The counter only survives while the synchronised value keeps differing.
    always_comb begin
        dcnt_d   = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (dcnt_q == DEB_T) begin
                stable_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            dcnt_q   <= '0;
            level_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            level_q  <= stable_q;
        end
    end

    assign level_o = level_q;

    if (HAS_FSM) begin : g_fsm
        localparam int unsigned MAXC = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
        localparam int unsigned HW   = $clog2(MAXC);
        localparam logic [HW-1:0] HOLD_T = HW'(HOLD_CYC - 1);
        localparam logic [HW-1:0] REP_T  = HW'(REP_CYC - 1);

        btn_state_t    state_q;
        logic [HW-1:0] hcnt_q;
        logic          press_q, release_q, rpt_q, long_q;

        // Release is tested first so it masks a terminal count in the same cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q   <= ST_IDLE;
                hcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                rpt_q     <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                rpt_q     <= 1'b0;
                long_q    <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (level_q) begin
                            press_q <= 1'b1;
                            rpt_q   <= 1'b1;
                            hcnt_q  <= '0;
                            state_q <= ST_PRESS;
                        end
                    end
                    ST_PRESS: begin
                        if (!level_q) begin
                            release_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else if (hcnt_q == HOLD_T) begin
                            long_q  <= 1'b1;
                            rpt_q   <= 1'b1;
                            hcnt_q  <= '0;
                            state_q <= ST_REPEAT;
                        end else begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (!level_q) begin
                            release_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else if (hcnt_q == REP_T) begin
                            rpt_q  <= 1'b1;
                            hcnt_q <= '0;
                        end else begin
                            hcnt_q <= hcnt_q + HW'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        hcnt_q  <= '0;
                    end
                endcase
            end
        end

        assign press_o   = press_q;
        assign release_o = release_q;
        assign rpt_o     = rpt_q;
        assign long_o    = long_q;
    end else begin : g_nofsm
        assign press_o   = 1'b0;
        assign release_o = 1'b0;
        assign rpt_o     = 1'b0;
        assign long_o    = 1'b0;
    end

endmodule

// File: rtl/button_conditioner.sv
// Pad front end: N_BTN debounced pushbuttons with event pulses plus the
// debounced do-not-disturb switch level. Event pulses lag raw edges by DEB_CYC+3.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N_BTN    = DEF_N_BTN,
    parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
    parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
    parameter int unsigned REP_CYC  = DEF_REP_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rpt,
    output logic [N_BTN-1:0] btn_long,
    output logic             sw_level
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_channel #(
            .DEB_CYC  (DEB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .REP_CYC  (REP_CYC),
            .HAS_FSM  (1'b1)
        ) u_ch (
            .clk_i     (clk),
            .rst_ni    (rst_n),
            .raw_i     (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .rpt_o     (btn_rpt[i]),
            .long_o    (btn_long[i])
        );
    end

    // The switch is a level only; its event outputs are tied off inside the channel.
    logic [3:0] sw_unused_evt;

    btn_channel #(
        .DEB_CYC  (DEB_CYC),
        .HOLD_CYC (HOLD_CYC),
        .REP_CYC  (REP_CYC),
        .HAS_FSM  (1'b0)
    ) u_sw (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .raw_i     (sw_raw),
        .level_o   (sw_level),
        .press_o   (sw_unused_evt[0]),
        .release_o (sw_unused_evt[1]),
        .rpt_o     (sw_unused_evt[2]),
        .long_o    (sw_unused_evt[3])
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus random stimulus; every cycle is compared against a window/time
// based reference model of the debounce and press/long/repeat timing.
module tb_button_conditioner;

    localparam int N    = 5;
    localparam int NC   = 6;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic         sw_raw = 1'b0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_rpt, btn_long;
    logic         sw_level;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN    (N),
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .REP_CYC  (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .sw_raw      (sw_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_rpt     (btn_rpt),
        .btn_long    (btn_long),
        .sw_level    (sw_level)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state: raw sample history, values seen after the
    // synchroniser, accepted value, and level as observed by the event logic.
    logic [63:0]   rawhist  [NC];
    logic [63:0]   seenhist [NC];
    logic          stable   [NC];
    logic          lvl      [NC];
    logic          lvl_prev [NC];
    int            press_at [NC];
    logic [NC-1:0] e_lvl, e_press, e_rel, e_rpt, e_long;

    // Observed event bookkeeping for the directed checks.
    int last_press[N], last_rel[N], last_long[N], last_rpt[N];
    int cnt_press[N], cnt_rel[N], cnt_long[N], cnt_rpt[N], cnt_lvl_hi[N];
    int sw_rise = -1;
    logic sw_prev = 1'b0;

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            rawhist[c]  = '0;
            seenhist[c] = '0;
            stable[c]   = 1'b0;
            lvl[c]      = 1'b0;
            lvl_prev[c] = 1'b0;
            press_at[c] = 0;
        end
        e_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0; e_long = '0;
    endtask

    task automatic model_edge(input logic [NC-1:0] raw);
        for (int c = 0; c < NC; c++) begin
            logic seen, lin, lpv;
            int h;
            seen = rawhist[c][1];
            lin  = lvl[c];
            lpv  = lvl_prev[c];
            rawhist[c]  = {rawhist[c][62:0], raw[c]};
            seenhist[c] = {seenhist[c][62:0], seen};
            e_press[c] = 1'b0; e_rel[c] = 1'b0; e_rpt[c] = 1'b0; e_long[c] = 1'b0;
            if (c < N) begin
                if (lin && !lpv) begin
                    e_press[c] = 1'b1;
                    e_rpt[c]   = 1'b1;
                    press_at[c] = cyc;
                end else if (!lin && lpv) begin
                    e_rel[c] = 1'b1;
                end else if (lin && lpv) begin
                    h = cyc - press_at[c];
                    if (h == HOLD) begin
                        e_long[c] = 1'b1;
                        e_rpt[c]  = 1'b1;
                    end else if (h > HOLD && ((h - HOLD) % REP) == 0) begin
                        e_rpt[c] = 1'b1;
                    end
                end
            end
            lvl_prev[c] = lin;
            lvl[c]      = stable[c];
            e_lvl[c]    = stable[c];
            // Accept a new value once DEB consecutive synchronised samples disagree.
            if (seenhist[c][DEB-1:0] == {DEB{~stable[c]}})
                stable[c] = ~stable[c];
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        checks++;
        assert (btn_level === e_lvl[N-1:0]) else begin
            errors++; $error("FAIL level cyc=%0d observed %b expected %b", cyc, btn_level, e_lvl[N-1:0]);
        end
        checks++;
        assert (btn_press === e_press[N-1:0]) else begin
            errors++; $error("FAIL press cyc=%0d observed %b expected %b", cyc, btn_press, e_press[N-1:0]);
        end
        checks++;
        assert (btn_release === e_rel[N-1:0]) else begin
            errors++; $error("FAIL release cyc=%0d observed %b expected %b", cyc, btn_release, e_rel[N-1:0]);
        end
        checks++;
        assert (btn_rpt === e_rpt[N-1:0]) else begin
            errors++; $error("FAIL rpt cyc=%0d observed %b expected %b", cyc, btn_rpt, e_rpt[N-1:0]);
        end
        checks++;
        assert (btn_long === e_long[N-1:0]) else begin
            errors++; $error("FAIL long cyc=%0d observed %b expected %b", cyc, btn_long, e_long[N-1:0]);
        end
        checks++;
        assert (sw_level === e_lvl[N]) else begin
            errors++; $error("FAIL sw_level cyc=%0d observed %b expected %b", cyc, sw_level, e_lvl[N]);
        end
        checks++;
        assert ((btn_press & btn_release) === '0) else begin
            errors++; $error("FAIL press_and_release cyc=%0d observed %b expected 0", cyc, btn_press & btn_release);
        end
    endtask

    task automatic tick();
        logic [NC-1:0] raw;
        raw = {sw_raw, btn_raw};
        @(posedge clk);
        cyc++;
        if (rst_n) model_edge(raw);
        else model_clear();
        #1;
        compare_outputs();
        for (int c = 0; c < N; c++) begin
            if (btn_press[c])   begin last_press[c] = cyc; cnt_press[c]++; end
            if (btn_release[c]) begin last_rel[c]   = cyc; cnt_rel[c]++;   end
            if (btn_long[c])    begin last_long[c]  = cyc; cnt_long[c]++;  end
            if (btn_rpt[c])     begin last_rpt[c]   = cyc; cnt_rpt[c]++;   end
            if (btn_level[c])   cnt_lvl_hi[c]++;
        end
        if (sw_level && !sw_prev) sw_rise = cyc;
        sw_prev = sw_level;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        #1;
        checks++;
        assert ({btn_level, btn_press, btn_release, btn_rpt, btn_long, sw_level} === '0) else begin
            errors++;
            $error("FAIL reset_clear observed %b expected 0",
                   {btn_level, btn_press, btn_release, btn_rpt, btn_long, sw_level});
        end
        model_clear();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int k, t, p0, r0, l0, q0;
        int rem[NC];

        for (int c = 0; c < N; c++) begin
            last_press[c] = -1; last_rel[c] = -1; last_long[c] = -1; last_rpt[c] = -1;
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_long[c] = 0; cnt_rpt[c] = 0; cnt_lvl_hi[c] = 0;
        end
        model_clear();

        // Reset state
        apply_reset(3);
        repeat (5) tick();

        // Clean press on up
        btn_raw[0] = 1'b1;
        k = cyc + 1;
        repeat (12) tick();
        btn_raw[0] = 1'b0;
        repeat (15) tick();
        chk("clean_press_time", last_press[0], k + 7);
        chk("clean_rpt_time", last_rpt[0], k + 7);
        chk("clean_release_time", last_rel[0], k + 19);
        chk("clean_no_long", cnt_long[0], 0);

        // Bounce on down
        p0 = cnt_press[1];
        for (int i = 0; i < 12; i++) begin
            btn_raw[1] = ((i % 4) < 2);
            tick();
        end
        btn_raw[1] = 1'b1;
        k = cyc + 1;
        repeat (15) tick();
        btn_raw[1] = 1'b0;
        repeat (12) tick();
        chk("bounce_press_count", cnt_press[1] - p0, 1);
        chk("bounce_press_time", last_press[1], k + 7);

        // Glitch on left
        btn_raw[2] = 1'b1;
        repeat (3) tick();
        btn_raw[2] = 1'b0;
        repeat (12) tick();
        chk("glitch_level", cnt_lvl_hi[2], 0);
        chk("glitch_pulses", cnt_press[2] + cnt_rel[2] + cnt_rpt[2] + cnt_long[2], 0);

        // Long hold on middle
        l0 = cnt_long[4]; q0 = cnt_rpt[4];
        btn_raw[4] = 1'b1;
        k = cyc + 1;
        repeat (60) tick();
        btn_raw[4] = 1'b0;
        repeat (15) tick();
        t = k + 7;
        chk("hold_press_time", last_press[4], t);
        chk("hold_long_count", cnt_long[4] - l0, 1);
        chk("hold_long_time", last_long[4], t + 20);
        chk("hold_rpt_count", cnt_rpt[4] - q0, 6);
        chk("hold_last_rpt", last_rpt[4], t + 52);
        chk("hold_release_time", last_rel[4], t + 60);

        // Simultaneous up/down with switch toggle
        btn_raw[1:0] = 2'b11;
        sw_raw = 1'b1;
        k = cyc + 1;
        repeat (12) tick();
        chk("simul_up", last_press[0], k + 7);
        chk("simul_down", last_press[1], k + 7);
        chk("sw_follow", sw_rise, k + 6);
        btn_raw[1:0] = 2'b00;
        sw_raw = 1'b0;
        repeat (12) tick();

        // Reset while right is in auto-repeat
        btn_raw[3] = 1'b1;
        repeat (35) tick();
        chk("right_long_before_reset", cnt_long[3], 1);
        apply_reset(3);
        k = cyc + 1;
        repeat (40) tick();
        chk("post_reset_press", last_press[3], k + 7);
        chk("post_reset_long", last_long[3], k + 27);
        btn_raw[3] = 1'b0;
        repeat (15) tick();

        // Random activity on all inputs
        for (int c = 0; c < NC; c++) rem[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (rem[c] == 0) begin
                    if (c < N) btn_raw[c] = 1'($urandom_range(0, 1));
                    else sw_raw = 1'($urandom_range(0, 1));
                    rem[c] = $urandom_range(1, 45);
                end else begin
                    rem[c]--;
                end
            end
            tick();
        end
        btn_raw = '0;
        sw_raw = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front end for the five navigation pushbuttons (up, down, left, right, middle) and the alarm do-not-disturb switch.
- Synchronises each raw pad input to clk and debounces it.
- Emits clean one-cycle event pulses to mode selection and alarm setting: press, release, long-press and auto-repeat.
- Sits between the board pads and every block that consumes button or switch state.

Parameters:
- N_BTN, 5, number of pushbutton channels; bit order {middle,right,left,down,up}, bit 0 = up.
- DEB_CYC, 2_000_000, cycles an input must hold a new value before it is accepted (20 ms at 100 MHz).
- HOLD_CYC, 60_000_000, cycles a button stays pressed before long-press and auto-repeat start (600 ms).
- REP_CYC, 15_000_000, auto-repeat period once repeat has started (150 ms).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw pushbuttons, active-high, asynchronous to clk.
- sw_raw  input  1  raw do-not-disturb slide switch.
- btn_level  output  N_BTN  debounced button level.
- btn_press  output  N_BTN  one-cycle pulse on each accepted press.
- btn_release  output  N_BTN  one-cycle pulse on each accepted release.
- btn_rpt  output  N_BTN  one-cycle pulse on press, on long-press entry, and every REP_CYC while held.
- btn_long  output  N_BTN  one-cycle pulse when a hold reaches HOLD_CYC.
- sw_level  output  1  debounced switch level.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all sync flops, stable levels, counters and outputs are 0; every FSM is in IDLE. Outputs clear immediately on rst_n falling.
- Synchroniser: two flops per input.
- Debounce, per input:
  - If the synchronised value equals the stable value, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEB_CYC-1 with the value still differing, the stable value takes the new value and the counter clears.
  - Any return to the stable value before then clears the counter. Glitches shorter than DEB_CYC are ignored.
- Latency: raw rising edge first sampled at edge k → btn_level high at k+DEB_CYC+2 → event pulses registered at k+DEB_CYC+3. Release uses the same latency.
- Per-button FSM (states IDLE, PRESS, REPEAT):
  - IDLE: on stable rise, pulse btn_press and btn_rpt; hold counter = 0; go to PRESS.
  - PRESS: counter increments.
    - On stable fall: pulse btn_release, go to IDLE.
    - Else, at counter == HOLD_CYC-1: pulse btn_long and btn_rpt, counter = 0, go to REPEAT.
  - REPEAT: counter increments.
    - On stable fall: pulse btn_release, go to IDLE.
    - Else, at counter == REP_CYC-1: pulse btn_rpt, counter = 0.
  - A release takes priority over a counter terminal count in the same cycle; no rpt or long pulse is issued in that cycle.
- Pulse rules:
  - btn_press and btn_release are never both high for one channel in the same cycle.
  - Channels are fully independent; simultaneous presses on several buttons produce pulses in the same cycle.
- Counter widths: debounce counter is clog2(DEB_CYC) bits; hold/repeat counter is clog2(max(HOLD_CYC,REP_CYC)) bits. Counters never wrap, because they clear at their terminal count.
- sw_level: synchroniser and debounce only, no FSM.
- Reset mid-operation: a button held through reset is treated as a new press once reset is released. btn_press fires DEB_CYC+3 cycles after the first sampling edge after reset.
- Parameter limits: DEB_CYC ≥ 2, HOLD_CYC ≥ 2, REP_CYC ≥ 2. Smaller values are unsupported.

Decomposition:
- Shared package holds:
  - button index constants: BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_MID=4;
  - default cycle-count constants;
  - FSM state encoding (IDLE=0, PRESS=1, REPEAT=2).
- One natural sub-module, btn_channel: synchroniser, debounce and FSM for one input, with the FSM disabled for the switch via a parameter.
- Top level instantiates N_BTN+1 channels.

Test Plan (DEB_CYC=4, HOLD_CYC=20, REP_CYC=8):
- Clean press: up high at k, held 12 cycles, then low.
  - btn_press[0] and btn_rpt[0] pulse at k+7; btn_level[0] high from k+6.
  - btn_release[0] pulses at k+19; no btn_long.
- Bounce: down toggles every 2 cycles for 12 cycles, then stays high → exactly one btn_press[1], 7 cycles after the final rising edge.
- Glitch: left high for 3 cycles → no btn_level or pulse activity on any output.
- Long hold: middle held 60 cycles, press pulse at t.
  - btn_long[4] once at t+20.
  - btn_rpt[4] at t, t+20, t+28, t+36, t+44, t+52.
  - btn_release[4] at t+60.
- Simultaneous: up and down rise on the same edge → btn_press[0] and btn_press[1] high in the same cycle. sw_raw toggled meanwhile → sw_level follows 6 cycles later.
- Reset mid-repeat: rst_n low for 3 cycles while right is in REPEAT.
  - All outputs go to 0 at once.
  - After reset release with the button still held: btn_press[3] 7 cycles later, then btn_long[3] 20 cycles after that.
